// File: rtl/collatz_unwind.sv
// Reverse Collatz walker: replays a stored parity record backwards from the final value,
// one inverse step per clock, to recover the start value of a forward run.
module collatz_unwind #(
    parameter int unsigned W    = 20,
    parameter int unsigned CW   = 16,
    parameter int unsigned NMAX = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st,
    input  logic [W-1:0]    kf,
    input  logic [NMAX-1:0] pv,
    input  logic [6:0]      n,
    output logic [CW-1:0]   co,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int unsigned IW    = $clog2(NMAX);
    localparam logic [6:0]  NMAX7 = 7'(NMAX);

    typedef enum logic [1:0] {StIdle, StStep, StDone} state_t;

    state_t          r_state;
    logic [W-1:0]    r_k;
    logic [6:0]      r_i;
    logic [NMAX-1:0] r_pvr;
    logic            r_fail;
    logic [CW-1:0]   r_co;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic [W-1:0]    w_km1;
    logic [W-1:0]    w_q;
    logic [W+1:0]    w_q3;
    logic [6:0]      w_im1;
    logic            w_bit;
    logic            w_odd_bad;
    logic            w_in_range;

    always_comb begin
        w_km1      = r_k - W'(1);
        w_q        = w_km1 / W'(3);
        // 3q at W+2 bits so the divisibility check cannot wrap
        w_q3       = ({2'b00, w_q} << 1) + {2'b00, w_q};
        w_odd_bad  = (r_k == '0) || (w_q3 != {2'b00, w_km1}) || !w_q[0];
        w_im1      = r_i - 7'd1;
        w_bit      = r_pvr[w_im1[IW-1:0]];
        w_in_range = (r_k[W-1:CW] == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_k     <= '0;
            r_i     <= '0;
            r_pvr   <= '0;
            r_fail  <= 1'b0;
            r_co    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (st) begin
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (n > NMAX7) begin
                            r_fail  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_fail  <= 1'b0;
                            r_k     <= kf;
                            r_pvr   <= pv;
                            r_i     <= n;
                            r_state <= (n == 7'd0) ? StDone : StStep;
                        end
                    end
                end
                StStep: begin
                    if (!w_bit && r_k[W-1]) begin
                        r_fail  <= 1'b1;
                        r_state <= StDone;
                    end else if (w_bit && w_odd_bad) begin
                        r_fail  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_k <= w_bit ? w_q : (r_k << 1);
                        r_i <= w_im1;
                        if (w_im1 == 7'd0) begin
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                    if (!r_fail && w_in_range) begin
                        r_co <= r_k[CW-1:0];
                    end else begin
                        r_err <= 1'b1;
                        r_co  <= '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign co   = r_co;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_collatz_unwind.sv
// Directed bench for collatz_unwind: vector table of complete runs plus hand sequences
// for mid-run reset, ignored start pulses and back-to-back runs.
module tb_collatz_unwind;

    logic        clk;
    logic        rst;
    logic        st;
    logic [19:0] kf;
    logic [63:0] pv;
    logic [6:0]  n;
    logic [15:0] co;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    collatz_unwind #(.W(20), .CW(16), .NMAX(64)) dut (
        .clk  (clk),
        .rst  (rst),
        .st   (st),
        .kf   (kf),
        .pv   (pv),
        .n    (n),
        .co   (co),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [19:0] kf;
        logic [63:0] pv;
        logic [6:0]  n;
        logic [15:0] co;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the accepting edge E0.
    task automatic start_run(input logic [19:0] k, input logic [63:0] p, input logic [6:0] nn);
        @(negedge clk);
        kf = k;
        pv = p;
        n  = nn;
        st = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
    endtask

    // Counts edges until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) seen = 1'b1;
        end
        if (!seen) lat = -1;
    endtask

    initial begin
        int lat;
        int ndone;
        logic [15:0] co_seen;

        vt[0]  = '{"seed6",      20'h00001, 64'h0A, 7'd8,  16'd6,   1'b0, 9};
        vt[1]  = '{"n0_27",      20'd27,    64'h0,  7'd0,  16'd27,  1'b0, 1};
        vt[2]  = '{"n0_range",   20'h10000, 64'h0,  7'd0,  16'd0,   1'b1, 1};
        vt[3]  = '{"odd_ndiv",   20'd5,     64'h1,  7'd1,  16'd0,   1'b1, 2};
        vt[4]  = '{"odd_even_q", 20'd7,     64'h1,  7'd1,  16'd0,   1'b1, 2};
        vt[5]  = '{"odd_zero",   20'd0,     64'h1,  7'd1,  16'd0,   1'b1, 2};
        vt[6]  = '{"ovf_shift",  20'h80000, 64'h0,  7'd1,  16'd0,   1'b1, 2};
        vt[7]  = '{"n65",        20'd1,     64'h0,  7'd65, 16'd0,   1'b1, 1};
        vt[8]  = '{"even4",      20'd16,    64'h0,  7'd4,  16'd256, 1'b0, 5};
        vt[9]  = '{"mid_err",    20'd1,     64'h2,  7'd3,  16'd0,   1'b1, 3};
        vt[10] = '{"n64_ovf",    20'd1,     64'h0,  7'd64, 16'd0,   1'b1, 21};
        vt[11] = '{"co_range",   20'h08000, 64'h0,  7'd1,  16'd0,   1'b1, 2};
        vt[12] = '{"odd_ok",     20'd4,     64'h1,  7'd1,  16'd1,   1'b0, 2};

        rst = 1'b1;
        st  = 1'b0;
        kf  = '0;
        pv  = '0;
        n   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_co",   32'(co),   32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err",  32'(err),  32'd0);

        for (int v = 0; v < 13; v++) begin
            start_run(vt[v].kf, vt[v].pv, vt[v].n);
            check({vt[v].name, "_busy"}, 32'(busy), 32'd1);
            wait_done(lat);
            check({vt[v].name, "_lat"}, 32'(lat), 32'(vt[v].lat));
            check({vt[v].name, "_co"},  32'(co),  32'(vt[v].co));
            check({vt[v].name, "_err"}, 32'(err), 32'(vt[v].err));
            @(posedge clk);
            #1;
            check({vt[v].name, "_done1"}, 32'(done), 32'd0);
            check({vt[v].name, "_hold"},  32'(co),   32'(vt[v].co));
        end

        // Mid-run asynchronous reset: co is 1 from the last vector
        start_run(20'd1, 64'h0A, 7'd8);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_co",   32'(co),   32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_err",  32'(err),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_run(20'd1, 64'h0A, 7'd8);
        wait_done(lat);
        check("rst_rerun_lat", 32'(lat), 32'd9);
        check("rst_rerun_co",  32'(co),  32'd6);

        // Start pulse during a run must be ignored
        start_run(20'd1, 64'h0A, 7'd8);
        repeat (2) @(posedge clk);
        @(negedge clk);
        kf = 20'd27;
        n  = 7'd0;
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        ndone   = 0;
        co_seen = '0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                co_seen = co;
            end
        end
        check("ign_ndone", 32'(ndone),   32'd1);
        check("ign_co",    32'(co_seen), 32'd6);

        // st held high: back-to-back runs with one IDLE cycle between them
        @(negedge clk);
        kf = 20'd1;
        pv = 64'h0A;
        n  = 7'd8;
        st = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat);
        check("b2b_lat1",  32'(lat),  32'd9);
        check("b2b_co1",   32'(co),   32'd6);
        check("b2b_gap",   32'(busy), 32'd0);
        @(posedge clk);
        #1;
        st = 1'b0;
        check("b2b_busy2", 32'(busy), 32'd1);
        check("b2b_err2",  32'(err),  32'd0);
        wait_done(lat);
        check("b2b_lat2",  32'(lat),  32'd9);
        check("b2b_co2",   32'(co),   32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/collatz_unwind.md
# collatz_unwind

Reverse-walk engine for the Collatz block. Given a final value, a step count and the per-step parity record of a forward run, it applies the inverse step once per clock to recover the 16-bit start value. Odd steps are inverted as (k−1)/3 and even steps as 2k. It is the decoder counterpart of the forward Collatz controller/datapath and is used to cross-check forward runs and to regenerate seeds from stored traces.

## Interface
Parameters:
- W, 20: working width of k; matches the forward k register.
- CW, 16: width of the recovered start value co.
- NMAX, 64: maximum step count; also the parity vector width.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- st  input  1  start request; sampled only in IDLE.
- kf  input  W  final value of the forward run.
- pv  input  NMAX  parity record; bit i = parity of the value before forward step i (step 0 first).
- n  input  7  number of forward steps, 0..NMAX.
- co  output  CW  recovered start value.
- busy  output  1  high in STEP and DONE.
- done  output  1  one-cycle completion pulse.
- err  output  1  run invalid; valid with done and held until the next start.

## Operation
- States: IDLE, STEP, DONE.
- Internal registers: k[W-1:0], i[6:0] (step index), pvr[NMAX-1:0].
- **IDLE**, st=1 at a clock edge:
  - If n > NMAX, go to DONE with err=1.
  - Otherwise latch k=kf, pvr=pv, i=n.
  - If n=0, go to DONE; else go to STEP.
- **STEP**, one inverse step per clock, using bit pvr[i−1]:
  - bit=0 (even step): k ← 2k. If k[W-1]=1 before the shift, this is overflow: go to DONE with err=1.
  - bit=1 (odd step): q=(k−1)/3, computed combinationally. Invalid if k=0, if 3q ≠ k−1, or if q is even; invalid goes to DONE with err=1. Otherwise k ← q.
  - Then i ← i−1. When i reaches 0, go to DONE.
- **DONE**, one cycle:
  - done=1.
  - If err=0 and k < 2^CW, co ← k[CW-1:0]. Otherwise err=1 and co ← 0.
  - Next state is IDLE.
- co and err hold their value from DONE until the next accepted start.
- Accepting a start clears err and leaves co unchanged.
- st is ignored in STEP and DONE.
- Arithmetic:
  - 3q is evaluated at W+2 bits.
  - k−1 is unsigned; the k=0 case is trapped explicitly, as above.
  - No truncation is silent; every out-of-range condition raises err.

## Timing
- Reset values: state IDLE; co=0, busy=0, done=0, err=0; k, i and pvr all 0.
- Reset asserted mid-run returns the block to these values immediately (asynchronous) and discards the run.
- Start accepted at edge E0. Then:
  - busy=1 from E0 through the edge that leaves DONE.
  - done=1 for exactly one cycle, following edge E0+n+1 (n valid steps).
  - For n=0, done follows E0+1.
- An error at step j (counted from the start) produces done after edge E0+j+1; the remaining steps are skipped.
- co and err are stable whenever done=1.
- st held high continuously starts a new run at the first IDLE cycle after DONE, i.e. back-to-back runs with a one-cycle IDLE gap.
- Inputs kf, pv and n are needed only at the accepting edge; they may change afterwards.

## Test plan
- Seed 6 → kf=1, n=8, pv=0x0A, st pulse → done 9 cycles after start, co=6, err=0. Intermediate k: 2, 4, 8, 16, 5, 10, 3, 6.
- kf=27, n=0 → done one cycle after start, co=27, err=0. kf=0x10000, n=0 → err=1, co=0.
- Invalid odd inverse:
  - kf=5, n=1, pv=1 → err=1 (4 is not divisible by 3).
  - kf=7, n=1, pv=1 → err=1 (q=2 is even).
  - kf=0, n=1, pv=1 → err=1.
- Overflow and range:
  - kf=0x80000, n=1, pv=0 → err=1 after the first step.
  - n=65 → err=1, done one cycle after start.
- Assert rst at cycle 4 of the seed-6 run → co, busy, done and err all 0 immediately. A following start with the same inputs yields co=6.
- Pulse st again during the seed-6 run → ignored; a single done, co=6. With st held high, a second run starts after one IDLE cycle.
